// File: rtl/col_fifo_arbiter_if.sv
// Handshake bundle between two column-word producers, the write arbiter
// and the shared column FIFO write port.
// The arbiter connects through the master modport.
// The environment (producers plus FIFO model) connects through the slave modport.
interface col_fifo_arbiter_if #(
  parameter int W = 24
);
  logic         req0_valid;
  logic [W-1:0] req0_data;
  logic         req0_ready;
  logic         req1_valid;
  logic [W-1:0] req1_data;
  logic         req1_ready;
  logic         fifo_full;
  logic         fifo_wr;
  logic [W-1:0] fifo_w_data;
  logic         grant_valid;
  logic         grant_id;

  modport master (
    input  req0_valid, req0_data, req1_valid, req1_data, fifo_full,
    output req0_ready, req1_ready, fifo_wr, fifo_w_data, grant_valid, grant_id
  );

  modport slave (
    output req0_valid, req0_data, req1_valid, req1_data, fifo_full,
    input  req0_ready, req1_ready, fifo_wr, fifo_w_data, grant_valid, grant_id
  );
endinterface

// File: rtl/col_fifo_arbiter.sv
// Two-requester round-robin write arbiter for the shared column FIFO.
// Each grant is burst-locked for at most BURST transfers.
// While the FIFO is full, the grant is held and the burst does not advance.
// Optional feature macro: COL_FIFO_ARB_STATS_EN.
//   When it is defined, the block adds per-requester 16-bit transfer
//   counters and a synchronous stats_clr input.
module col_fifo_arbiter #(
  parameter int B      = 8,
  parameter int COLUMN = 3,
  parameter int BURST  = 4
) (
  input  logic        clk,
  input  logic        reset_n,
`ifdef COL_FIFO_ARB_STATS_EN
  input  logic        stats_clr,
  output logic [15:0] xfer_cnt0,
  output logic [15:0] xfer_cnt1,
`endif
  col_fifo_arbiter_if.master bus
);

  localparam int W  = COLUMN * B;
  localparam int CW = $clog2(BURST + 1);
  localparam logic [CW-1:0] BURST_LAST = CW'(BURST - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic          rr_ptr_q, rr_ptr_d;
  logic [CW-1:0] burst_cnt_q, burst_cnt_d;

  logic          cur_id;
  logic          own_valid;
  logic          other_valid;
  logic          xfer;
  logic          ready0;
  logic          ready1;
  logic [W-1:0]  w_data;
  logic          grant_valid;
  logic          grant_id;

  // Next-state, grant outputs and the write port, all decoded from the current grant.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    burst_cnt_d = burst_cnt_q;
    cur_id      = 1'b0;
    own_valid   = 1'b0;
    other_valid = 1'b0;
    xfer        = 1'b0;
    ready0      = 1'b0;
    ready1      = 1'b0;
    w_data      = '0;
    grant_valid = 1'b0;
    grant_id    = 1'b0;

    case (state_q)
      IDLE: begin
        burst_cnt_d = '0;
        if (bus.req0_valid && bus.req1_valid) begin
          state_d = rr_ptr_q ? GRANT1 : GRANT0;
        end else if (bus.req0_valid) begin
          state_d = GRANT0;
        end else if (bus.req1_valid) begin
          state_d = GRANT1;
        end
      end

      GRANT0, GRANT1: begin
        cur_id      = (state_q == GRANT1);
        own_valid   = cur_id ? bus.req1_valid : bus.req0_valid;
        other_valid = cur_id ? bus.req0_valid : bus.req1_valid;
        grant_valid = 1'b1;
        grant_id    = cur_id;
        ready0      = !cur_id && !bus.fifo_full;
        ready1      = cur_id && !bus.fifo_full;
        xfer        = own_valid && !bus.fifo_full;
        w_data      = cur_id ? bus.req1_data : bus.req0_data;

        if (!own_valid || (xfer && (burst_cnt_q == BURST_LAST))) begin
          // Release: the other requester wins if it is waiting.
          // Otherwise the current requester is regranted with a fresh burst.
          rr_ptr_d    = !cur_id;
          burst_cnt_d = '0;
          if (other_valid) begin
            state_d = cur_id ? GRANT0 : GRANT1;
          end else if (own_valid) begin
            state_d = state_q;
          end else begin
            state_d = IDLE;
          end
        end else if (xfer) begin
          burst_cnt_d = burst_cnt_q + CW'(1);
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.req0_ready  = ready0;
  assign bus.req1_ready  = ready1;
  assign bus.fifo_wr     = xfer;
  assign bus.fifo_w_data = w_data;
  assign bus.grant_valid = grant_valid;
  assign bus.grant_id    = grant_id;

  // Arbitration state register; reset drops any partial burst immediately.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      rr_ptr_q    <= 1'b0;
      burst_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

`ifdef COL_FIFO_ARB_STATS_EN
  logic [15:0] xfer_cnt0_q, xfer_cnt0_d;
  logic [15:0] xfer_cnt1_q, xfer_cnt1_d;

  // Per-requester accepted-transfer counters.
  // A clear wins over a same-cycle transfer; the counters wrap naturally.
  always_comb begin
    xfer_cnt0_d = xfer_cnt0_q;
    xfer_cnt1_d = xfer_cnt1_q;
    if (stats_clr) begin
      xfer_cnt0_d = '0;
      xfer_cnt1_d = '0;
    end else if (xfer) begin
      if (cur_id) begin
        xfer_cnt1_d = xfer_cnt1_q + 16'd1;
      end else begin
        xfer_cnt0_d = xfer_cnt0_q + 16'd1;
      end
    end
  end

  // Counter registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      xfer_cnt0_q <= '0;
      xfer_cnt1_q <= '0;
    end else begin
      xfer_cnt0_q <= xfer_cnt0_d;
      xfer_cnt1_q <= xfer_cnt1_d;
    end
  end

  assign xfer_cnt0 = xfer_cnt0_q;
  assign xfer_cnt1 = xfer_cnt1_q;
`endif

endmodule

// File: tb/tb_col_fifo_arbiter.sv
// Testbench for col_fifo_arbiter.
// Directed phases drive random data, plus one long phase of random
// valid/full patterns. Every cycle is checked against a behavioural model
// that tracks the owner, the words sent in the current burst, and the
// round-robin pointer.
module tb_col_fifo_arbiter;
  localparam int B      = 8;
  localparam int COLUMN = 3;
  localparam int BURST  = 4;
  localparam int W      = COLUMN * B;

  logic clk = 1'b0;
  logic reset_n;
  logic stats_clr;
`ifdef COL_FIFO_ARB_STATS_EN
  logic [15:0] xfer_cnt0;
  logic [15:0] xfer_cnt1;
`endif

  always #5 clk = ~clk;

  col_fifo_arbiter_if #(.W(W)) bus ();

  col_fifo_arbiter #(.B(B), .COLUMN(COLUMN), .BURST(BURST)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
`ifdef COL_FIFO_ARB_STATS_EN
    .stats_clr (stats_clr),
    .xfer_cnt0 (xfer_cnt0),
    .xfer_cnt1 (xfer_cnt1),
`endif
    .bus       (bus)
  );

  // Reference model state: owner -1 means nobody holds the grant.
  int          m_owner;
  int          m_rr;
  int          m_sent;
  logic [15:0] m_cnt0;
  logic [15:0] m_cnt1;
  bit          hold0;
  bit          hold1;

  int n_vec  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    m_owner = -1;
    m_rr    = 0;
    m_sent  = 0;
    m_cnt0  = '0;
    m_cnt1  = '0;
    hold0   = 1'b0;
    hold1   = 1'b0;
  endtask

  // Compare outputs against the model for the current inputs,
  // then advance the model across the coming clock edge.
  task automatic checkOutput();
    bit v0, v1, full, clr, e_wr, own, oth, rel;
    logic [W-1:0] e_data;
    int o;
    o    = m_owner;
    v0   = bus.req0_valid;
    v1   = bus.req1_valid;
    full = bus.fifo_full;
    clr  = stats_clr;
    e_wr   = !full && ((o == 0 && v0) || (o == 1 && v1));
    e_data = (o == 0) ? bus.req0_data : (o == 1) ? bus.req1_data : '0;

    chk("grant_valid", 32'(bus.grant_valid), 32'(o >= 0));
    chk("grant_id",    32'(bus.grant_id),    32'(o == 1));
    chk("req0_ready",  32'(bus.req0_ready),  32'(o == 0 && !full));
    chk("req1_ready",  32'(bus.req1_ready),  32'(o == 1 && !full));
    chk("fifo_wr",     32'(bus.fifo_wr),     32'(e_wr));
    chk("fifo_w_data", 32'(bus.fifo_w_data), 32'(e_data));
`ifdef COL_FIFO_ARB_STATS_EN
    chk("xfer_cnt0", 32'(xfer_cnt0), 32'(m_cnt0));
    chk("xfer_cnt1", 32'(xfer_cnt1), 32'(m_cnt1));
`endif

    if (clr) begin
      m_cnt0 = '0;
      m_cnt1 = '0;
    end else if (e_wr) begin
      if (o == 0) m_cnt0 = m_cnt0 + 16'd1;
      else        m_cnt1 = m_cnt1 + 16'd1;
    end

    if (o < 0) begin
      m_sent = 0;
      if (v0 && v1) m_owner = m_rr;
      else if (v0)  m_owner = 0;
      else if (v1)  m_owner = 1;
    end else begin
      own = (o == 0) ? v0 : v1;
      oth = (o == 0) ? v1 : v0;
      if (e_wr) m_sent++;
      rel = !own || (e_wr && m_sent == BURST);
      if (rel) begin
        m_rr   = 1 - o;
        m_sent = 0;
        if (oth)      m_owner = 1 - o;
        else if (own) m_owner = o;
        else          m_owner = -1;
      end
    end

    hold0 = v0 && !(o == 0 && e_wr);
    hold1 = v1 && !(o == 1 && e_wr);
  endtask

  // Drive one cycle of inputs.
  // A requester keeps its data while its last word is still pending.
  task automatic applyStimulus(input bit v0, input bit v1, input bit full, input bit clr);
    @(negedge clk);
    if (!hold0) bus.req0_data = W'($urandom());
    if (!hold1) bus.req1_data = W'($urandom());
    bus.req0_valid = v0;
    bus.req1_valid = v1;
    bus.fifo_full  = full;
    stats_clr      = clr;
    #1;
    checkOutput();
  endtask

  // Assert reset with the given valids, check the quiet outputs, then release.
  task automatic doReset(input bit v0, input bit v1);
    @(negedge clk);
    reset_n        = 1'b0;
    bus.req0_valid = v0;
    bus.req1_valid = v1;
    bus.fifo_full  = 1'b0;
    stats_clr      = 1'b0;
    bus.req0_data  = W'($urandom());
    bus.req1_data  = W'($urandom());
    #1;
    chk("rst_grant_valid", 32'(bus.grant_valid), 32'd0);
    chk("rst_grant_id",    32'(bus.grant_id),    32'd0);
    chk("rst_req0_ready",  32'(bus.req0_ready),  32'd0);
    chk("rst_req1_ready",  32'(bus.req1_ready),  32'd0);
    chk("rst_fifo_wr",     32'(bus.fifo_wr),     32'd0);
    chk("rst_fifo_w_data", 32'(bus.fifo_w_data), 32'd0);
`ifdef COL_FIFO_ARB_STATS_EN
    chk("rst_cnt0", 32'(xfer_cnt0), 32'd0);
    chk("rst_cnt1", 32'(xfer_cnt1), 32'd0);
`endif
    modelReset();
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    checkOutput();
  endtask

  initial begin
    reset_n        = 1'b0;
    stats_clr      = 1'b0;
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    bus.req0_data  = '0;
    bus.req1_data  = '0;
    bus.fifo_full  = 1'b0;
    modelReset();

    $display("[TB] reset with both requesters valid, then burst lock");
    doReset(1'b1, 1'b1);
    for (int i = 0; i < 16; i++) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
`ifdef COL_FIFO_ARB_STATS_EN
    chk("burst_cnt0", 32'(xfer_cnt0), 32'd8);
    chk("burst_cnt1", 32'(xfer_cnt1), 32'd7);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    chk("clr_cnt0", 32'(xfer_cnt0), 32'd0);
    chk("clr_cnt1", 32'(xfer_cnt1), 32'd0);
`endif

    $display("[TB] full stall mid-burst");
    doReset(1'b1, 1'b1);
    for (int i = 0; i < 2; i++) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);

    $display("[TB] early release by requester 1");
    doReset(1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);

    $display("[TB] single requester stream");
    doReset(1'b1, 1'b0);
    for (int i = 0; i < 12; i++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);

    $display("[TB] random traffic");
    for (int i = 0; i < 400; i++) begin
      applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                    $urandom_range(0, 3) == 0, $urandom_range(0, 31) == 0);
    end

    $display("[TB] reset in the middle of a burst");
    for (int i = 0; i < 2; i++) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    doReset(1'b1, 1'b1);
    for (int i = 0; i < 6; i++) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/col_fifo_arbiter.md
Name: col_fifo_arbiter

Overview:
- Two-requester write arbiter for the shared column FIFO, which stores COLUMN×B-bit column words.
- Each requester (e.g. two pixel-column producers) presents column words with a valid/ready handshake.
- The block grants the FIFO write port round-robin, with per-grant burst locking, and drives the FIFO wr/w_data inputs from the granted requester, throttled by the FIFO full flag.

Parameters:
B, 8, bits per word
COLUMN, 3, words per column entry
BURST, 4, max transfers per grant before forced release; legal values ≥1

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  asynchronous active-low reset
req0_valid  in  1  requester 0 has a word
req0_data  in  COLUMN*B  requester 0 column word
req0_ready  out  1  requester 0 word accepted this cycle when valid&ready
req1_valid  in  1  requester 1 has a word
req1_data  in  COLUMN*B  requester 1 column word
req1_ready  out  1  requester 1 word accepted this cycle when valid&ready
fifo_full  in  1  FIFO full flag
fifo_wr  out  1  FIFO write strobe
fifo_w_data  out  COLUMN*B  FIFO write data
grant_valid  out  1  a requester currently holds the grant
grant_id  out  1  granted requester index (0/1)

Behaviour:
- Reset: one clock; reset is asynchronous and active-low.
  - reset_n low → state IDLE, rr_ptr=0, burst_cnt=0.
  - All outputs 0 (ready, fifo_wr, fifo_w_data, grant_valid, grant_id).
- States: IDLE, GRANT0, GRANT1.
  - grant_valid=1 in GRANTn.
  - grant_id=n in GRANTn; grant_id=0 in IDLE.
- readyN = (state==GRANTN) & ~fifo_full. Combinational, no registered stall.
- Transfer: xfer = granted valid & granted ready.
  - fifo_wr = xfer, same cycle.
  - fifo_w_data = granted reqN_data in GRANTn, else 0.
  - fifo_wr is never asserted while fifo_full=1.
- IDLE:
  - Both valid → grant the requester indexed by rr_ptr.
  - One valid → grant that one.
  - None → stay.
  - Grant is registered; the first transfer is possible one cycle after valid is seen in IDLE.
  - burst_cnt←0 on every grant.
- GRANTn, width/counting:
  - burst_cnt (width clog2(BURST+1)) increments on each xfer.
  - No increment on stall (fifo_full) cycles.
- GRANTn, release conditions:
  - (a) xfer with burst_cnt==BURST-1.
  - (b) reqN_valid==0 in a cycle; no transfer occurs that cycle.
- On release:
  - rr_ptr←other index.
  - Other requester valid → go directly to GRANTother (no idle bubble).
  - Else own valid still high → regrant same (GRANTn, burst_cnt←0).
  - Else IDLE.
- fifo_full during a grant:
  - Grant is held and the burst does not advance.
  - Release by (b) still applies while full.
- BURST=1: every transfer releases; with both requesters valid and FIFO not full, grants strictly alternate, one word per cycle.
- Requesters must hold data stable while valid & ~ready. The block does not check this.
- Reset mid-burst: immediate return to IDLE, no partial-transfer state retained.

Optional Feature:
- Macro: COL_FIFO_ARB_STATS_EN.
- Defined: adds outputs xfer_cnt0 and xfer_cnt1, 16 bits each, with this behaviour:
  - Count accepted transfers per requester.
  - Wrap at 0xFFFF→0.
  - Reset to 0 on reset_n low.
  - Input stats_clr (synchronous) zeroes both; clear has priority over a same-cycle increment.
- Undefined: ports and counters absent; the remaining behaviour is identical.

Test Plan:
- Reset state: reset_n low with both valids high → all outputs 0. Release reset → GRANT0 next cycle, grant_id=0 (rr_ptr=0).
- Burst lock: BURST=4, both valid continuously, fifo_full=0 → 4 writes from req0 data, then 4 from req1, alternating with no bubble. fifo_wr high every cycle after the first.
- Full stall: mid-burst after 2 req0 transfers, hold fifo_full=1 for 3 cycles → fifo_wr=0, req0_ready=0, grant stays 0. After full drops, exactly 2 more req0 writes, then switch to req1.
- Early release: req1 granted, drops valid after 1 transfer while req0 idle → IDLE next cycle, rr_ptr=0. Then req0 valid → GRANT0.
- Single requester: only req0 valid, 10 words, BURST=4 → 10 consecutive writes, regranted to req0 after each burst with no bubble. fifo_w_data matches req0_data in order.
- Stats (COL_FIFO_ARB_STATS_EN): the burst-lock scenario for 16 cycles → xfer_cnt0=8, xfer_cnt1=7 (first cycle is grant latency). stats_clr pulse → both 0 next cycle.
